// File: rtl/div_issue_ctrl_pkg.sv
// Shared EXE-stage types for the divider issue sequencer: divider command
// encoding, sequencer FSM states and the latched request record.
package div_issue_ctrl_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned REQ_TAG_W = 5;

    typedef enum logic [1:0] {
        CMD_REMU = 2'b00,
        CMD_DIV  = 2'b01,
        CMD_DIVU = 2'b10,
        CMD_REM  = 2'b11
    } div_cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DRAIN = 3'd4
    } div_issue_state_e;

    // Op as captured at acceptance; drives the divider for the whole op.
    typedef struct packed {
        logic [DATA_W-1:0]    op1;
        logic [DATA_W-1:0]    op2;
        div_cmd_e             cmd;
        logic [REQ_TAG_W-1:0] tag;
    } div_req_t;

    // Everything that determines a divider result; the tag is not part of it.
    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        div_cmd_e          cmd;
    } div_key_t;

    function automatic div_key_t make_key(input logic [DATA_W-1:0] op1,
                                          input logic [DATA_W-1:0] op2,
                                          input div_cmd_e          cmd);
        div_key_t k;
        k.op1 = op1;
        k.op2 = op2;
        k.cmd = cmd;
        return k;
    endfunction

endpackage

// File: rtl/div_result_cache.sv
// One-entry cache of the last completed divide: key, result and valid bit.
// With CACHE_EN = 0 the lookup never hits, so every op goes to the divider.
module div_result_cache
    import div_issue_ctrl_pkg::*;
#(
    parameter bit CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  div_key_t          lookup_key,
    output logic              hit,
    output logic [DATA_W-1:0] hit_data,
    input  logic              upd_en,
    input  div_key_t          upd_key,
    input  logic [DATA_W-1:0] upd_data
);

    logic              valid_q;
    div_key_t          key_q;
    logic [DATA_W-1:0] data_q;

    // Store the most recent completed op; reset invalidates the entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            key_q   <= '0;
            data_q  <= '0;
        end else if (upd_en && CACHE_EN) begin
            valid_q <= 1'b1;
            key_q   <= upd_key;
            data_q  <= upd_data;
        end
    end

    // Exact-match lookup against the incoming op.
    always_comb begin
        hit      = CACHE_EN && valid_q && (key_q == lookup_key);
        hit_data = data_q;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// EXE-stage sequencer in front of the iterative divider.
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; the producer holds valid and payload until then. req_ready is high
// only in IDLE (flush in that cycle kills the offered op). res_valid is high
// only in HOLD and res_data/res_tag do not change while it is waiting.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W    = REQ_TAG_W,
    parameter bit          CACHE_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_op1_i,
    input  logic [31:0]       req_op2_i,
    input  logic [1:0]        req_cmd_i,
    input  logic [TAG_W-1:0]  req_tag_i,
    input  logic              flush_i,
    output logic              div_start_o,
    output logic [31:0]       div_op1_o,
    output logic [31:0]       div_op2_o,
    output logic [1:0]        div_cmd_o,
    input  logic              div_done_i,
    input  logic [31:0]       div_res_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [31:0]       res_data_o,
    output logic [TAG_W-1:0]  res_tag_o,
    output logic              busy_o,
    output div_issue_state_e  dbg_state
);

    div_issue_state_e  state, state_nxt;
    div_req_t          req_q;
    logic [31:0]       res_data_q;
    logic              accept;
    logic              cache_hit;
    logic [31:0]       cache_data;
    logic              cache_upd;
    div_key_t          lookup_key;
    div_key_t          upd_key;

    assign accept     = (state == ST_IDLE) && req_valid_i && !flush_i;
    // A done that coincides with a flush is discarded and never cached.
    assign cache_upd  = (state == ST_WAIT) && div_done_i && !flush_i;
    assign lookup_key = make_key(req_op1_i, req_op2_i, div_cmd_e'(req_cmd_i));
    assign upd_key    = make_key(req_q.op1, req_q.op2, req_q.cmd);

    div_result_cache #(
        .CACHE_EN (CACHE_EN)
    ) u_cache (
        .clk        (clk),
        .reset_n    (reset_n),
        .lookup_key (lookup_key),
        .hit        (cache_hit),
        .hit_data   (cache_data),
        .upd_en     (cache_upd),
        .upd_key    (upd_key),
        .upd_data   (div_res_i)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the divider cannot be aborted, so a flush while it
    // is running parks in DRAIN until its done pulse.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) state_nxt = cache_hit ? ST_HOLD : ST_ISSUE;
            end
            ST_ISSUE: begin
                state_nxt = flush_i ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (flush_i)         state_nxt = div_done_i ? ST_IDLE : ST_DRAIN;
                else if (div_done_i) state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (flush_i || res_ready_i) state_nxt = ST_IDLE;
            end
            ST_DRAIN: begin
                if (div_done_i) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        req_ready_o = (state == ST_IDLE);
        div_start_o = (state == ST_ISSUE);
        res_valid_o = (state == ST_HOLD);
        busy_o      = (state != ST_IDLE);
    end

    // Latch the accepted op and capture the result from cache or divider.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_q      <= '0;
            res_data_q <= '0;
        end else begin
            if (accept) begin
                req_q.op1 <= req_op1_i;
                req_q.op2 <= req_op2_i;
                req_q.cmd <= div_cmd_e'(req_cmd_i);
                req_q.tag <= REQ_TAG_W'(req_tag_i);
                if (cache_hit) res_data_q <= cache_data;
            end
            if (cache_upd) res_data_q <= div_res_i;
        end
    end

    assign div_op1_o  = req_q.op1;
    assign div_op2_o  = req_q.op2;
    assign div_cmd_o  = req_q.cmd;
    assign res_data_o = res_data_q;
    assign res_tag_o  = TAG_W'(req_q.tag);
    assign dbg_state  = state;

endmodule
